// File: rtl/tlul_sram_responder.sv
// -----------------------------------------------------------------------------
// tlul_sram_responder
//
// Purpose:
//   TL-UL responder in front of a DEPTH x 32-bit SRAM with byte write enables.
//   Each accepted A beat is decoded, legal Puts write memory and legal Gets
//   read it on the acceptance edge. Every beat produces one D response, which
//   is queued in a 2-entry FIFO. Illegal beats do not touch memory and are
//   answered with d_denied=1.
//
// Handshake semantics (both channels):
//   A beat transfers on a rising edge where valid & ready are both 1. A sender
//   holding valid must keep its payload stable until the transfer. a_ready
//   depends only on the registered FIFO count (and reset), never on d_ready or
//   any A input. The D payload is the FIFO head and only changes on a pop.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   a_valid/a_ready       A channel handshake
//   a_opcode, a_param,    A channel payload (a_param is ignored)
//   a_size, a_source,
//   a_address, a_mask,
//   a_data
//   d_valid/d_ready       D channel handshake
//   d_opcode, d_size,     D channel payload (d_corrupt is tied to 0;
//   d_source, d_data,     all d_* read as 0 while d_valid is 0)
//   d_denied, d_corrupt
//
// Configuration:
//   TLUL_RESP_PROTOCOL_CHECK_EN - when defined, compiles in simulation-only
//   A/D protocol checks that call $fatal on a violation. Port behaviour is
//   identical with or without it.
// -----------------------------------------------------------------------------
module tlul_sram_responder #(
    parameter int DEPTH    = 16,
    parameter int SOURCE_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [31:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic [31:0]         d_data,
    output logic                d_denied,
    output logic                d_corrupt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK  = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          size;
        logic [SOURCE_W-1:0] source;
        logic [31:0]         data;
        logic                denied;
    } rsp_t;

    // FIFO bookkeeping
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    rsp_t       fifo_q [2];

    // Memory: contents are not reset so they survive a mid-operation reset
    logic [31:0] mem_q [DEPTH];

    logic          push, pop;
    logic          op_ok, size_ok, align_ok, range_ok, legal;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   lane_mask;
    logic          mem_we;
    rsp_t          new_rsp;
    rsp_t          head;

    logic unused_a_param;
    assign unused_a_param = ^a_param;

    // Handshakes: a_ready comes from registered state only
    assign a_ready = ~reset & (count_q != 2'd2);
    assign d_valid = ~reset & (count_q != 2'd0);
    assign push    = a_valid & a_ready;
    assign pop     = d_valid & d_ready;

    // A beat decode
    always_comb begin
        op_ok   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) ||
                  (a_opcode == OP_GET);
        size_ok = (a_size != 2'd3);
        case (a_size)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~a_address[0];
            default: align_ok = (a_address[1:0] == 2'b00);
        endcase
        range_ok = (a_address[31:2] < 30'(DEPTH));
        legal    = op_ok & size_ok & align_ok & range_ok;
    end

    assign word_idx  = a_address[AW+1:2];
    assign rd_word   = mem_q[word_idx];
    assign lane_mask = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};
    assign mem_we    = push & legal & (a_opcode != OP_GET);

    // Response built at acceptance. A Get sees any Put accepted on an earlier
    // edge because the memory array is read combinationally here.
    always_comb begin
        new_rsp        = '0;
        new_rsp.size   = a_size;
        new_rsp.source = a_source;
        if (!legal) begin
            new_rsp.denied = 1'b1;
            new_rsp.opcode = (a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACCESS_ACK;
        end else if (a_opcode == OP_GET) begin
            new_rsp.opcode = OP_ACK_DATA;
            new_rsp.data   = rd_word & lane_mask;
        end else begin
            new_rsp.opcode = OP_ACCESS_ACK;
        end
    end

    // FIFO pointer/count next state
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage: entries need no reset, the outputs are gated by d_valid
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= new_rsp;
        end
    end

    // Byte-enabled memory write
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign d_opcode  = d_valid ? head.opcode : 3'd0;
    assign d_size    = d_valid ? head.size   : 2'd0;
    assign d_source  = d_valid ? head.source : '0;
    assign d_data    = d_valid ? head.data   : 32'd0;
    assign d_denied  = d_valid ? head.denied : 1'b0;
    assign d_corrupt = 1'b0;

`ifdef TLUL_RESP_PROTOCOL_CHECK_EN
`ifndef SYNTHESIS
    logic                chk_stall_q;
    logic [2:0]          chk_opcode_q;
    logic [2:0]          chk_param_q;
    logic [1:0]          chk_size_q;
    logic [SOURCE_W-1:0] chk_source_q;
    logic [31:0]         chk_address_q;
    logic [3:0]          chk_mask_q;
    logic [31:0]         chk_data_q;
    logic [3:0]          chk_full_mask;

    always_comb begin
        case (a_size)
            2'd0:    chk_full_mask = 4'b0001 << a_address[1:0];
            2'd1:    chk_full_mask = a_address[1] ? 4'b1100 : 4'b0011;
            default: chk_full_mask = 4'b1111;
        endcase
    end

    always @(posedge clock) begin
        if (reset) begin
            chk_stall_q <= 1'b0;
        end else begin
            chk_stall_q   <= a_valid & ~a_ready;
            chk_opcode_q  <= a_opcode;
            chk_param_q   <= a_param;
            chk_size_q    <= a_size;
            chk_source_q  <= a_source;
            chk_address_q <= a_address;
            chk_mask_q    <= a_mask;
            chk_data_q    <= a_data;
            if (chk_stall_q && !a_valid) begin
                $display("tlul_sram_responder: a_valid dropped while stalled");
                $fatal(1);
            end
            if (chk_stall_q && a_valid &&
                ((a_opcode != chk_opcode_q) || (a_param != chk_param_q) ||
                 (a_size != chk_size_q) || (a_source != chk_source_q) ||
                 (a_address != chk_address_q) || (a_mask != chk_mask_q) ||
                 (a_data != chk_data_q))) begin
                $display("tlul_sram_responder: A payload changed while stalled");
                $fatal(1);
            end
            if (a_valid && (a_opcode == OP_PUT_FULL) && (a_mask != chk_full_mask)) begin
                $display("tlul_sram_responder: PutFullData with partial mask");
                $fatal(1);
            end
            if (d_valid && $isunknown(d_ready)) begin
                $display("tlul_sram_responder: d_ready unknown while d_valid");
                $fatal(1);
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_tlul_sram_responder.sv
module tb_tlul_sram_responder;

    localparam int DEPTH    = 16;
    localparam int SOURCE_W = 4;
    localparam int RSP_W    = 3 + 2 + SOURCE_W + 32 + 1;

    logic                clock;
    logic                reset;
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic [31:0]         d_data;
    logic                d_denied;
    logic                d_corrupt;

    int n_vec = 0;
    int n_err = 0;
    int dready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    // Reference model: word-array memory and in-order expected responses
    logic [31:0]      model_mem [DEPTH];
    logic [RSP_W-1:0] exp_q [$];

    tlul_sram_responder #(.DEPTH(DEPTH), .SOURCE_W(SOURCE_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_data    (d_data),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d miscompares so far, required completion", n_err);
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [RSP_W-1:0] pack_rsp(input logic [2:0] op, input logic [1:0] sz,
                                                  input logic [SOURCE_W-1:0] src,
                                                  input logic [31:0] data, input logic den);
        return {op, sz, src, data, den};
    endfunction

    task automatic model_accept(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data,
                                input logic [SOURCE_W-1:0] src);
        int unsigned a;
        int unsigned widx;
        bit          legal;
        logic [31:0] word;
        logic [31:0] rdata;
        a     = addr;
        widx  = a / 4;
        legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (sz <= 2'd2) &&
                ((a % (32'd1 << sz)) == 0) && (widx < DEPTH);
        if (!legal) begin
            exp_q.push_back(pack_rsp((op == 3'd4) ? 3'd1 : 3'd0, sz, src, 32'd0, 1'b1));
        end else if (op == 3'd4) begin
            word  = model_mem[widx];
            rdata = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) rdata[8*b +: 8] = word[8*b +: 8];
            end
            exp_q.push_back(pack_rsp(3'd1, sz, src, rdata, 1'b0));
        end else begin
            word = model_mem[widx];
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
            end
            model_mem[widx] = word;
            exp_q.push_back(pack_rsp(3'd0, sz, src, 32'd0, 1'b0));
        end
    endtask

    // ---------------- scoreboard / monitor (samples on falling edge) ----------------
    always @(negedge clock) begin
        logic [RSP_W-1:0] e;
        if (reset) begin
            check_eq("rst_a_ready", 64'(a_ready), 64'(0));
            check_eq("rst_d_valid", 64'(d_valid), 64'(0));
            check_eq("rst_d_bus", 64'({d_opcode, d_size, d_source, d_data, d_denied, d_corrupt}), 64'(0));
            exp_q.delete();
        end else begin
            check_eq("a_ready", 64'(a_ready), 64'(exp_q.size() < 2));
            check_eq("d_valid", 64'(d_valid), 64'(exp_q.size() != 0));
            if (d_valid && d_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("d_opcode",  64'(d_opcode),  64'(e[RSP_W-1 -: 3]));
                check_eq("d_size",    64'(d_size),    64'(e[RSP_W-4 -: 2]));
                check_eq("d_source",  64'(d_source),  64'(e[RSP_W-6 -: SOURCE_W]));
                check_eq("d_data",    64'(d_data),    64'(e[32:1]));
                check_eq("d_denied",  64'(d_denied),  64'(e[0]));
                check_eq("d_corrupt", 64'(d_corrupt), 64'(0));
            end
            if (a_valid && a_ready) begin
                model_accept(a_opcode, a_size, a_address, a_mask, a_data, a_source);
            end
        end
    end

    // ---------------- d_ready driver ----------------
    initial begin
        d_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (dready_mode)
                0:       d_ready = 1'b0;
                1:       d_ready = 1'b1;
                default: d_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- A channel driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic [SOURCE_W-1:0] src);
        bit acc;
        acc       = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = sz;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_source  = src;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clock);
            acc = a_ready && !reset;
            @(posedge clock);
            #1;
        end
        if (!acc) check_eq("a_accept_timeout", 64'(0), 64'(1));
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [3:0] full_mask(input logic [1:0] sz, input logic [31:0] addr);
        logic [3:0] m;
        case (sz)
            2'd0:    m = 4'b0001 << addr[1:0];
            2'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        int          r;

        reset     = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 2'd0;
        a_source  = '0;
        a_address = 32'd0;
        a_mask    = 4'd0;
        a_data    = 32'd0;
        dready_mode = 1;

        // Reset held three cycles, then check the idle state right after release
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_a_ready", 64'(a_ready), 64'(1));
        check_eq("post_rst_d_valid", 64'(d_valid), 64'(0));
        check_eq("post_rst_d_bus", 64'({d_opcode, d_size, d_source, d_data, d_denied, d_corrupt}), 64'(0));
        @(posedge clock);
        #1;

        // Give every word a known value so the model is fully defined
        for (int i = 0; i < DEPTH; i++) begin
            send_a(3'd0, 2'd2, 32'(i * 4), 4'hF, $urandom(), 4'(i));
        end
        wait_drain();

        // PutFull then Get to the same word on the next cycle
        send_a(3'd0, 2'd2, 32'h8, 4'hF, 32'hDEADBEEF, 4'd3);
        send_a(3'd4, 2'd2, 32'h8, 4'hF, 32'd0, 4'd5);
        wait_drain();

        // PutPartial of one byte lane, then full readback
        send_a(3'd1, 2'd2, 32'h8, 4'h2, 32'h0000AA00, 4'd6);
        send_a(3'd4, 2'd2, 32'h8, 4'hF, 32'd0, 4'd7);
        wait_drain();

        // Backpressure: three Gets with d_ready low, release after a few cycles
        dready_mode = 0;
        idle(1);
        send_a(3'd4, 2'd2, 32'h8, 4'hF, 32'd0, 4'd1);
        send_a(3'd4, 2'd2, 32'hC, 4'hF, 32'd0, 4'd2);
        fork
            send_a(3'd4, 2'd2, 32'h10, 4'hF, 32'd0, 4'd3);
            begin
                idle(3);
                dready_mode = 1;
            end
        join
        wait_drain();

        // Illegal beats: out of range, misaligned, bad opcode; then readback
        send_a(3'd4, 2'd2, 32'h40, 4'hF, 32'd0, 4'd8);
        send_a(3'd4, 2'd2, 32'h2, 4'hF, 32'd0, 4'd9);
        send_a(3'd2, 2'd2, 32'h8, 4'hF, 32'h12345678, 4'd10);
        send_a(3'd0, 2'd2, 32'h44, 4'hF, 32'h55555555, 4'd11);
        send_a(3'd4, 2'd2, 32'h8, 4'hF, 32'd0, 4'd12);
        send_a(3'd4, 2'd2, 32'h0, 4'hF, 32'd0, 4'd13);
        wait_drain();

        // Reset with two responses queued; memory must survive
        dready_mode = 0;
        idle(1);
        send_a(3'd0, 2'd2, 32'h20, 4'hF, 32'hCAFEF00D, 4'd1);
        send_a(3'd0, 2'd2, 32'h24, 4'hF, 32'h0BADC0DE, 4'd2);
        idle(1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        dready_mode = 1;
        idle(1);
        send_a(3'd4, 2'd2, 32'h20, 4'hF, 32'd0, 4'd3);
        send_a(3'd4, 2'd2, 32'h24, 4'hF, 32'd0, 4'd4);
        wait_drain();

        // Randomized traffic with random backpressure and idle gaps
        dready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      op = 3'd0;
            else if (r <= 5) op = 3'd1;
            else if (r <= 8) op = 3'd4;
            else begin
                case ($urandom_range(0, 4))
                    0:       op = 3'd2;
                    1:       op = 3'd3;
                    2:       op = 3'd5;
                    3:       op = 3'd6;
                    default: op = 3'd7;
                endcase
            end
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r    = int'($urandom_range(0, 9));
            addr = {26'd0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
            if (r == 0) begin
                addr = $urandom();
            end else if (r == 1) begin
                addr[1:0] = 2'($urandom_range(0, 3));
            end else begin
                case (sz)
                    2'd0:    addr[1:0] = 2'($urandom_range(0, 3));
                    2'd1:    addr[1]   = 1'($urandom_range(0, 1));
                    default: addr[1:0] = 2'b00;
                endcase
            end
            mask = (op == 3'd0) ? full_mask(sz, addr) : 4'($urandom_range(0, 15));
            send_a(op, sz, addr, mask, $urandom(), 4'($urandom_range(0, 15)));
            idle(int'($urandom_range(0, 2)));
        end
        dready_mode = 1;
        wait_drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
